// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - fetch PC owner with one-outstanding imem request and a prefetch FIFO
module instr_fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        RST,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        instr_ready,
   input  logic        redir,
   input  logic [31:0] redir_pc
);

   localparam int             PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW:0]    CNT_DEPTH = (PW+1)'(DEPTH);
   localparam logic [PW-1:0]  PTR_ONE   = PW'(1);

   typedef enum logic [1:0] {IDLE, BUSY, DROP} fetchState_t;

   fetchState_t   state;
   logic [31:0]   fetchPc;
   logic [31:0]   pcMem    [DEPTH];
   logic [31:0]   instrMem [DEPTH];
   logic [PW-1:0] headPtr;
   logic [PW-1:0] tailPtr;
   logic [PW:0]   count;

   logic          push;
   logic          pop;
   logic [PW:0]   countNext;
   logic          roomNext;
   logic [31:0]   redirPc;
   logic [31:0]   pcPlus4;

   always_comb begin
      pop       = instr_valid && instr_ready;
      push      = (state == BUSY) && imem_ack;
      countNext = count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
      roomNext  = countNext < CNT_DEPTH;
      redirPc   = redir_pc & ~32'h3;
      pcPlus4   = fetchPc + 32'd4;
   end

   assign instr_valid = (count != '0);
   assign instr       = instrMem[headPtr];
   assign instr_pc    = pcMem[headPtr];

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         fetchPc   <= RESET_PC;
         imem_req  <= 1'b0;
         imem_addr <= RESET_PC;
         headPtr   <= '0;
         tailPtr   <= '0;
         count     <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pcMem[i]    <= '0;
            instrMem[i] <= '0;
         end
      end else if (redir) begin
         // Flush wins over any pop or ack this cycle; an unacked request must still be absorbed.
         headPtr <= '0;
         tailPtr <= '0;
         count   <= '0;
         fetchPc <= redirPc;
         if (state != IDLE && !imem_ack) begin
            state <= DROP;
         end else begin
            state     <= BUSY;
            imem_req  <= 1'b1;
            imem_addr <= redirPc;
         end
      end else begin
         if (push) begin
            pcMem[tailPtr]    <= fetchPc;
            instrMem[tailPtr] <= imem_rdata;
            tailPtr           <= tailPtr + PTR_ONE;
            fetchPc           <= pcPlus4;
         end
         if (pop) begin
            headPtr <= headPtr + PTR_ONE;
         end
         count <= countNext;

         case (state)
            IDLE: begin
               if (roomNext) begin
                  state     <= BUSY;
                  imem_req  <= 1'b1;
                  imem_addr <= fetchPc;
               end
            end
            BUSY: begin
               if (imem_ack) begin
                  if (roomNext) begin
                     imem_addr <= pcPlus4;
                  end else begin
                     state    <= IDLE;
                     imem_req <= 1'b0;
                  end
               end
            end
            DROP: begin
               // Stale word is thrown away; the queue is empty so reissue immediately.
               if (imem_ack) begin
                  state     <= BUSY;
                  imem_addr <= fetchPc;
               end
            end
            default: begin
               state    <= IDLE;
               imem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - directed bench for instr_fetch_queue with a variable-latency memory model
module tb_instr_fetch_queue;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready = 1'b0;
   logic        redir = 1'b0;
   logic [31:0] redir_pc = 32'h0;

   int lat = 0;
   int waitCnt = 0;
   int nCompared = 0;
   int nMismatch = 0;
   logic found;

   instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
      .CLK(CLK),
      .RST(RST),
      .imem_req(imem_req),
      .imem_addr(imem_addr),
      .imem_ack(imem_ack),
      .imem_rdata(imem_rdata),
      .instr_valid(instr_valid),
      .instr(instr),
      .instr_pc(instr_pc),
      .instr_ready(instr_ready),
      .redir(redir),
      .redir_pc(redir_pc)
   );

   always #5 CLK = ~CLK;

   // Memory answers once the request has been held for lat cycles; lat=0 acks in the request cycle.
   always @(posedge CLK) begin
      if (RST || !imem_req || imem_ack) waitCnt <= 0;
      else waitCnt <= waitCnt + 1;
   end
   assign imem_ack   = imem_req && (waitCnt >= lat);
   assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

   function automatic logic [31:0] word(input logic [31:0] pc);
      return pc ^ 32'hA5A5_0000;
   endfunction

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nCompared++;
      assert (obs === exp)
      else begin
         nMismatch++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      // Reset state
      step();
      step();
      chk("rst_req", imem_req, 1'b0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_valid", instr_valid, 1'b0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_pc", instr_pc, 32'h0);

      // Zero-wait streaming: one instruction per cycle from cycle 2
      RST = 1'b0;
      instr_ready = 1'b1;
      step();
      chk("c1_req", imem_req, 1'b1);
      chk("c1_addr", imem_addr, 32'h0);
      chk("c1_valid", instr_valid, 1'b0);
      step();
      for (int k = 0; k < 5; k++) begin
         chk("stream_valid", instr_valid, 1'b1);
         chk("stream_pc", instr_pc, 32'(k * 4));
         chk("stream_instr", instr, word(32'(k * 4)));
         chk("stream_req", imem_req, 1'b1);
         step();
      end

      // Back-pressure: refill from 0 with consumer stalled, queue must cap at 4
      instr_ready = 1'b0;
      redir = 1'b1;
      redir_pc = 32'h0;
      step();
      redir = 1'b0;
      chk("bp_flush_valid", instr_valid, 1'b0);
      chk("bp_addr", imem_addr, 32'h0);
      repeat (9) step();
      chk("bp_req_low", imem_req, 1'b0);
      chk("bp_valid", instr_valid, 1'b1);
      chk("bp_head_pc", instr_pc, 32'h0);
      chk("bp_head_instr", instr, word(32'h0));
      instr_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         step();
         if (k == 1) begin
            chk("bp_resume_req", imem_req, 1'b1);
            chk("bp_resume_addr", imem_addr, 32'h10);
         end
         chk("bp_drain_pc", instr_pc, 32'(k * 4));
         chk("bp_drain_instr", instr, word(32'(k * 4)));
      end

      // Redirect one cycle after a slow request for address 8 goes out
      lat = 3;
      redir = 1'b1;
      redir_pc = 32'h0;
      step();
      redir = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (imem_req && imem_addr == 32'h8) begin
            found = 1'b1;
            break;
         end
         step();
      end
      chk("lat_req8_seen", found, 1'b1);
      step();
      chk("lat_no_ack_yet", imem_ack, 1'b0);
      redir = 1'b1;
      redir_pc = 32'h0000_0103;
      step();
      redir = 1'b0;
      chk("drop_valid", instr_valid, 1'b0);
      chk("drop_req", imem_req, 1'b1);
      chk("drop_addr_held", imem_addr, 32'h8);
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (imem_addr != 32'h8) begin
            found = 1'b1;
            break;
         end
         step();
      end
      chk("drop_reissue_seen", found, 1'b1);
      chk("drop_reissue_addr", imem_addr, 32'h100);
      chk("drop_reissue_req", imem_req, 1'b1);
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (instr_valid) begin
            found = 1'b1;
            break;
         end
         step();
      end
      chk("drop_first_seen", found, 1'b1);
      chk("drop_first_pc", instr_pc, 32'h100);
      chk("drop_first_instr", instr, word(32'h100));

      // Redirect coinciding with an ack and a pop
      lat = 0;
      repeat (6) step();
      chk("coinc_pre_valid", instr_valid, 1'b1);
      chk("coinc_pre_ack", imem_ack, 1'b1);
      redir = 1'b1;
      redir_pc = 32'h200;
      step();
      redir = 1'b0;
      chk("coinc_valid", instr_valid, 1'b0);
      chk("coinc_req", imem_req, 1'b1);
      chk("coinc_addr", imem_addr, 32'h200);
      step();
      chk("coinc_first_valid", instr_valid, 1'b1);
      chk("coinc_first_pc", instr_pc, 32'h200);
      chk("coinc_first_instr", instr, word(32'h200));

      // PC wraps from the top of the address space
      redir = 1'b1;
      redir_pc = 32'hFFFF_FFF8;
      step();
      redir = 1'b0;
      chk("wrap_flush", instr_valid, 1'b0);
      step();
      chk("wrap_pc0", instr_pc, 32'hFFFF_FFF8);
      step();
      chk("wrap_pc1", instr_pc, 32'hFFFF_FFFC);
      step();
      chk("wrap_pc2", instr_pc, 32'h0000_0000);
      chk("wrap_instr2", instr, word(32'h0));

      // Reset while busy with two entries queued
      instr_ready = 1'b0;
      lat = 3;
      redir = 1'b1;
      redir_pc = 32'h40;
      step();
      redir = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (imem_req && imem_addr == 32'h48) begin
            found = 1'b1;
            break;
         end
         step();
      end
      chk("mid_req48_seen", found, 1'b1);
      chk("mid_valid", instr_valid, 1'b1);
      chk("mid_head_pc", instr_pc, 32'h40);
      RST = 1'b1;
      step();
      chk("mrst_req", imem_req, 1'b0);
      chk("mrst_addr", imem_addr, 32'h0);
      chk("mrst_valid", instr_valid, 1'b0);
      chk("mrst_instr", instr, 32'h0);
      chk("mrst_pc", instr_pc, 32'h0);
      RST = 1'b0;
      lat = 0;
      instr_ready = 1'b1;
      step();
      chk("restart_req", imem_req, 1'b1);
      chk("restart_addr", imem_addr, 32'h0);
      step();
      chk("restart_valid", instr_valid, 1'b1);
      chk("restart_pc", instr_pc, 32'h0);
      chk("restart_instr", instr, word(32'h0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
      $finish;
   end

endmodule
